shift_seq_arb: RTL and testbench
================================

SHIFT_SEQ_ARB -- requirements
Module: shift_seq_arb

Interface
REQ-001 The block SHALL have parameter STEP, default 1: bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1: requester n has a shift pending.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1: requester n's operands are accepted this cycle.
REQ-006 The block SHALL have ports req0_op and req1_op, input, 2: 00 SLL, 01 SRL, 10 SRA, 11 pass.
REQ-007 The block SHALL have ports req0_a and req1_a, input, 32: operand to shift.
REQ-008 The block SHALL have ports req0_shamt and req1_shamt, input, 5: shift amount, 0..31.
REQ-009 The block SHALL have port res_valid, output, 1: res_data and res_id are valid.
REQ-010 The block SHALL have port res_ready, input, 1: the consumer accepts the result.
REQ-011 The block SHALL have port res_data, output, 32: shifted result.
REQ-012 The block SHALL have port res_id, output, 1: the requester that owns the result.
REQ-013 The block SHALL have port busy, output, 1: high in SHIFT and DONE.

Function
REQ-014 The block SHALL implement three states: IDLE, SHIFT, DONE.
REQ-015 In IDLE, ready SHALL be driven combinationally to the one granted valid requester only; no ready SHALL be asserted outside IDLE.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant the requester that is not last_grant; with one valid, grant that requester.
REQ-017 On accept, the block SHALL capture op, a and shamt into working registers and record id.
REQ-018 On accept, the next state SHALL be DONE if shamt==0 or op==11, otherwise SHIFT.
REQ-019 In SHIFT, each cycle SHALL shift the working value by k = min(STEP, remaining) and set remaining to remaining - k.
REQ-020 The SHIFT fill SHALL be: SLL zero-fill from the LSB; SRL zero-fill from the MSB; SRA fill with the captured bit 31.
REQ-021 The block SHALL transition SHIFT->DONE on the cycle remaining reaches 0.
REQ-022 SHIFT SHALL occupy ceil(shamt/STEP) cycles.
REQ-023 Accept-to-res_valid latency SHALL be ceil(shamt/STEP)+1 cycles, and 1 cycle for shamt==0 or op 11.
REQ-024 The final result SHALL equal A<<shamt, A>>shamt or $signed(A)>>>shamt respectively; op 11 SHALL return A unchanged.
REQ-025 In DONE, res_valid SHALL be 1 and res_data/res_id SHALL be held stable until res_ready is high.
REQ-026 On the DONE handshake, the block SHALL update last_grant to id and go to IDLE; a new accept is possible the following cycle, with no same-cycle accept in DONE.
REQ-027 Request inputs that change while busy SHALL be ignored and SHALL NOT affect the operation in flight.
REQ-028 res_data SHALL be driven only from the working register; no combinational path from req*_a to res_data.
REQ-029 A STEP greater than the remaining amount SHALL never over-shift; the final step is truncated.

Reset
REQ-030 Asserting rst at any time, including mid-SHIFT or in DONE, SHALL immediately force state IDLE, abandoning any operation in flight.
REQ-031 During and after reset: res_valid=0, res_data=0, res_id=0, busy=0, remaining=0, last_grant=1 (so req0 wins the first contention).
REQ-032 Ready outputs SHALL be 0 while rst is high.

Verification
REQ-033 Scenario 1: STEP=1, req0 SRL a=0x80000000, shamt=31, res_ready=1 -> res_data=0x00000001, res_id=0, res_valid 32 cycles after accept.
REQ-034 Scenario 2: STEP=1, req1 SRA a=0xF0000000, shamt=4 -> res_data=0xFF000000, res_id=1, latency 5.
REQ-035 Scenario 3: STEP=4, SLL a=0x00000001, shamt=6 -> 2 SHIFT cycles (4 then 2), res_data=0x00000040, latency 3.
REQ-036 Scenario 4: both valid continuously, shamt=0 -> grants alternate 0,1,0,1; each result 1 cycle after accept; ready one-hot.
REQ-037 Scenario 5: hold res_ready=0 for 5 cycles in DONE -> res_valid, res_data and res_id stable; no ready asserted; req inputs changed meanwhile have no effect.
REQ-038 Scenario 6: rst pulsed during SHIFT (shamt=20, cycle 5) -> outputs zero asynchronously; after release, req0 is granted first under contention and the prior operation is never reported.

Source files
------------

// File: rtl/shift_seq_arb_if.sv
// Request/result bundle for shift_seq_arb.
//   req0_*/req1_* : two requesters, valid/ready handshake with op, a and shamt operands
//   res_*         : single result channel, valid/ready handshake with data and owner id
//   busy          : block is working on or holding a result
// Modport slave is the shifter's view; master is the view of whoever drives the requests.
interface shift_seq_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_op;
    logic [31:0] req0_a;
    logic [4:0]  req0_shamt;
    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_op;
    logic [31:0] req1_a;
    logic [4:0]  req1_shamt;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_id;
    logic        busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_shamt,
        input  req1_valid, req1_op, req1_a, req1_shamt,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_id, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_shamt,
        output req1_valid, req1_op, req1_a, req1_shamt,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/shift_seq_arb.sv
// Two-requester round-robin arbiter in front of a multi-cycle barrel-less shifter.
// A granted request is captured, shifted STEP bits per cycle, and the result is held
// on the result channel until the consumer takes it.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : shift_seq_arb_if.slave (request inputs, ready outputs, result channel, busy)
// Parameter STEP: bits shifted per SHIFT cycle (1, 2, 4 or 8).
module shift_seq_arb #(
    parameter int unsigned STEP = 1
) (
    input logic            clk,
    input logic            rst,
    shift_seq_arb_if.slave bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [1:0] OpSll  = 2'b00;
    localparam logic [1:0] OpSrl  = 2'b01;
    localparam logic [1:0] OpSra  = 2'b10;
    localparam logic [1:0] OpPass = 2'b11;

    localparam logic [4:0] StepAmt = 5'(STEP);

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  rem_q, rem_d;
    logic        id_q, id_d;
    logic        last_grant_q, last_grant_d;

    logic        grant_id;
    logic        accept;
    logic [1:0]  sel_op;
    logic [31:0] sel_a;
    logic [4:0]  sel_shamt;
    logic [4:0]  step_k;
    logic [31:0] shifted;

    // Round-robin: under contention the requester that did not win last time goes next.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = bus.req1_valid;
        end
    end

    // Gating with rst keeps ready low for the whole reset pulse, not only after it.
    assign accept         = (state_q == StIdle) && !rst && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = accept && !grant_id;
    assign bus.req1_ready = accept && grant_id;

    assign sel_op    = grant_id ? bus.req1_op    : bus.req0_op;
    assign sel_a     = grant_id ? bus.req1_a     : bus.req0_a;
    assign sel_shamt = grant_id ? bus.req1_shamt : bus.req0_shamt;

    // Final step is truncated to what is left so the total never exceeds shamt.
    assign step_k = (rem_q < StepAmt) ? rem_q : StepAmt;

    // SRA fill comes from work_q[31], which an arithmetic shift never changes,
    // so it always equals the sign bit captured at accept.
    always_comb begin
        case (op_q)
            OpSll:   shifted = work_q << step_k;
            OpSrl:   shifted = work_q >> step_k;
            OpSra:   shifted = $unsigned($signed(work_q) >>> step_k);
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        work_d       = work_q;
        rem_d        = rem_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d   = sel_op;
                    work_d = sel_a;
                    id_d   = grant_id;
                    if ((sel_shamt == 5'd0) || (sel_op == OpPass)) begin
                        rem_d   = 5'd0;
                        state_d = StDone;
                    end else begin
                        rem_d   = sel_shamt;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                work_d = shifted;
                rem_d  = rem_q - step_k;
                if (rem_q == step_k) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.res_ready) begin
                    last_grant_d = id_q;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= OpSll;
            work_q       <= 32'd0;
            rem_q        <= 5'd0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            work_q       <= work_d;
            rem_q        <= rem_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Result comes straight from registers; request operands never reach res_data directly.
    assign bus.res_valid = (state_q == StDone);
    assign bus.res_data  = work_q;
    assign bus.res_id    = id_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_seq_arb.sv
module tb_shift_seq_arb;

    logic clk;
    logic rst;

    shift_seq_arb_if if1 ();
    shift_seq_arb_if if4 ();

    shift_seq_arb #(.STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    shift_seq_arb #(.STEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [31:0] exp;
        int          lat1;
        int          lat4;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_req(input int n, input logic v, input logic [1:0] op,
                           input logic [31:0] a, input logic [4:0] sh);
        if (n == 0) begin
            if1.req0_valid = v; if1.req0_op = op; if1.req0_a = a; if1.req0_shamt = sh;
            if4.req0_valid = v; if4.req0_op = op; if4.req0_a = a; if4.req0_shamt = sh;
        end else begin
            if1.req1_valid = v; if1.req1_op = op; if1.req1_a = a; if1.req1_shamt = sh;
            if4.req1_valid = v; if4.req1_op = op; if4.req1_a = a; if4.req1_shamt = sh;
        end
    endtask

    task automatic set_ready(input logic r);
        if1.res_ready = r;
        if4.res_ready = r;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [1:0] exp_rdy;
        bit seen1, seen4;
        @(negedge clk);
        set_req(int'(v.id), 1'b1, v.op, v.a, v.shamt);
        #1;
        exp_rdy = v.id ? 2'b10 : 2'b01;
        chk($sformatf("v%0d ready s1", i), {30'd0, if1.req1_ready, if1.req0_ready}, {30'd0, exp_rdy});
        chk($sformatf("v%0d ready s4", i), {30'd0, if4.req1_ready, if4.req0_ready}, {30'd0, exp_rdy});
        @(posedge clk);
        #1;
        set_req(int'(v.id), 1'b0, 2'b00, 32'd0, 5'd0);
        seen1 = 1'b0;
        seen4 = 1'b0;
        for (int c = 1; c <= 100 && !(seen1 && seen4); c++) begin
            if (!seen1 && if1.res_valid) begin
                seen1 = 1'b1;
                chk($sformatf("v%0d lat s1", i), c, v.lat1);
                chk($sformatf("v%0d data s1", i), if1.res_data, v.exp);
                chk($sformatf("v%0d id s1", i), {31'd0, if1.res_id}, {31'd0, v.id});
            end
            if (!seen4 && if4.res_valid) begin
                seen4 = 1'b1;
                chk($sformatf("v%0d lat s4", i), c, v.lat4);
                chk($sformatf("v%0d data s4", i), if4.res_data, v.exp);
                chk($sformatf("v%0d id s4", i), {31'd0, if4.res_id}, {31'd0, v.id});
            end
            if (!(seen1 && seen4)) begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen1) chk($sformatf("v%0d timeout s1", i), 32'd0, 32'd1);
        if (!seen4) chk($sformatf("v%0d timeout s4", i), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d idle after hs", i), {30'd0, if1.busy, if4.busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 2'b01, 32'h80000000, 5'd31, 32'h00000001, 32, 9};
        vecs[1]  = '{1'b1, 2'b10, 32'hF0000000, 5'd4,  32'hFF000000, 5,  2};
        vecs[2]  = '{1'b0, 2'b00, 32'h00000001, 5'd6,  32'h00000040, 7,  3};
        vecs[3]  = '{1'b1, 2'b00, 32'h12345678, 5'd0,  32'h12345678, 1,  1};
        vecs[4]  = '{1'b0, 2'b11, 32'hDEADBEEF, 5'd17, 32'hDEADBEEF, 1,  1};
        vecs[5]  = '{1'b1, 2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 32, 9};
        vecs[6]  = '{1'b0, 2'b10, 32'h7FFFFFFF, 5'd3,  32'h0FFFFFFF, 4,  2};
        vecs[7]  = '{1'b1, 2'b01, 32'hA5A5A5A5, 5'd8,  32'h00A5A5A5, 9,  3};
        vecs[8]  = '{1'b0, 2'b00, 32'h0000FFFF, 5'd16, 32'hFFFF0000, 17, 5};
        vecs[9]  = '{1'b1, 2'b01, 32'h12345678, 5'd1,  32'h091A2B3C, 2,  2};
        vecs[10] = '{1'b0, 2'b00, 32'h80000001, 5'd5,  32'h00000020, 6,  3};
        vecs[11] = '{1'b1, 2'b10, 32'hC0000000, 5'd7,  32'hFF800000, 8,  3};

        // Reset state, with both requesters pushing: no ready while rst is high.
        rst = 1'b1;
        set_ready(1'b1);
        set_req(0, 1'b1, 2'b00, 32'h1, 5'd1);
        set_req(1, 1'b1, 2'b00, 32'h2, 5'd1);
        #12;
        chk("rst ready s1", {30'd0, if1.req1_ready, if1.req0_ready}, 32'd0);
        chk("rst ready s4", {30'd0, if4.req1_ready, if4.req0_ready}, 32'd0);
        chk("rst res_valid", {30'd0, if1.res_valid, if4.res_valid}, 32'd0);
        chk("rst res_data s1", if1.res_data, 32'd0);
        chk("rst res_data s4", if4.res_data, 32'd0);
        chk("rst res_id", {30'd0, if1.res_id, if4.res_id}, 32'd0);
        chk("rst busy", {30'd0, if1.busy, if4.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b0, 2'b00, 32'd0, 5'd0);
        set_req(1, 1'b0, 2'b00, 32'd0, 5'd0);

        // Contention with shamt 0: grants alternate starting with requester 0.
        @(negedge clk);
        set_req(0, 1'b1, 2'b00, 32'h11111111, 5'd0);
        set_req(1, 1'b1, 2'b00, 32'h22222222, 5'd0);
        for (int g = 0; g < 4; g++) begin
            logic [1:0] er;
            er = (g % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk($sformatf("rr%0d ready s1", g), {30'd0, if1.req1_ready, if1.req0_ready}, {30'd0, er});
            chk($sformatf("rr%0d ready s4", g), {30'd0, if4.req1_ready, if4.req0_ready}, {30'd0, er});
            @(negedge clk);
            chk($sformatf("rr%0d valid", g), {30'd0, if1.res_valid, if4.res_valid}, 32'd3);
            chk($sformatf("rr%0d id s1", g), {31'd0, if1.res_id}, g % 2);
            chk($sformatf("rr%0d id s4", g), {31'd0, if4.res_id}, g % 2);
            chk($sformatf("rr%0d data s1", g), if1.res_data,
                (g % 2 == 0) ? 32'h11111111 : 32'h22222222);
            chk($sformatf("rr%0d no ready in done", g),
                {28'd0, if1.req1_ready, if1.req0_ready, if4.req1_ready, if4.req0_ready}, 32'd0);
            if (g == 3) begin
                set_req(0, 1'b0, 2'b00, 32'd0, 5'd0);
                set_req(1, 1'b0, 2'b00, 32'd0, 5'd0);
            end
            @(negedge clk);
        end

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Back-pressure in DONE: result held, request churn ignored.
        @(negedge clk);
        set_ready(1'b0);
        set_req(0, 1'b1, 2'b00, 32'h00000001, 5'd2);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 2'b00, 32'd0, 5'd0);
        begin
            bit both;
            both = 1'b0;
            for (int c = 0; c < 20 && !both; c++) begin
                if (if1.res_valid && if4.res_valid) both = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            if (!both) chk("hold timeout", 32'd0, 32'd1);
        end
        for (int h = 0; h < 5; h++) begin
            set_req(0, 1'b1, 2'b01, 32'hFFFF0000 + h, 5'd3);
            set_req(1, 1'b1, 2'b10, 32'h0F0F0000 + h, 5'd0);
            @(negedge clk);
            chk($sformatf("hold%0d valid", h), {30'd0, if1.res_valid, if4.res_valid}, 32'd3);
            chk($sformatf("hold%0d data s1", h), if1.res_data, 32'h00000004);
            chk($sformatf("hold%0d data s4", h), if4.res_data, 32'h00000004);
            chk($sformatf("hold%0d id", h), {30'd0, if1.res_id, if4.res_id}, 32'd0);
            chk($sformatf("hold%0d no ready", h),
                {28'd0, if1.req1_ready, if1.req0_ready, if4.req1_ready, if4.req0_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        set_ready(1'b1);
        @(posedge clk);
        #1;
        // last_grant is now 0, so requester 1 wins this contention.
        chk("post-hold rr s1", {30'd0, if1.req1_ready, if1.req0_ready}, 32'd2);
        chk("post-hold rr s4", {30'd0, if4.req1_ready, if4.req0_ready}, 32'd2);
        set_req(0, 1'b0, 2'b00, 32'd0, 5'd0);
        set_req(1, 1'b0, 2'b00, 32'd0, 5'd0);

        // Reset in the middle of SHIFT.
        @(negedge clk);
        set_req(0, 1'b1, 2'b01, 32'hFFFFFFFF, 5'd20);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 2'b00, 32'd0, 5'd0);
        repeat (4) @(posedge clk);
        #2;
        chk("pre-rst busy", {30'd0, if1.busy, if4.busy}, 32'd3);
        rst = 1'b1;
        set_req(0, 1'b1, 2'b00, 32'hAAAA0000, 5'd0);
        set_req(1, 1'b1, 2'b00, 32'h0000BBBB, 5'd0);
        #1;
        chk("midrst res_valid", {30'd0, if1.res_valid, if4.res_valid}, 32'd0);
        chk("midrst data s1", if1.res_data, 32'd0);
        chk("midrst data s4", if4.res_data, 32'd0);
        chk("midrst busy", {30'd0, if1.busy, if4.busy}, 32'd0);
        chk("midrst ready",
            {28'd0, if1.req1_ready, if1.req0_ready, if4.req1_ready, if4.req0_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst rr s1", {30'd0, if1.req1_ready, if1.req0_ready}, 32'd1);
        chk("postrst rr s4", {30'd0, if4.req1_ready, if4.req0_ready}, 32'd1);
        @(negedge clk);
        chk("postrst valid", {30'd0, if1.res_valid, if4.res_valid}, 32'd3);
        chk("postrst id", {30'd0, if1.res_id, if4.res_id}, 32'd0);
        chk("postrst data s1", if1.res_data, 32'hAAAA0000);
        chk("postrst data s4", if4.res_data, 32'hAAAA0000);
        set_req(0, 1'b0, 2'b00, 32'd0, 5'd0);
        set_req(1, 1'b0, 2'b00, 32'd0, 5'd0);
        @(posedge clk);
        #1;
        chk("final idle", {30'd0, if1.busy, if4.busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
